// File: rtl/tlb.sv
// 16-entry fully associative LoongArch TLB: two combinational search ports, TLBRD/TLBWR port,
// INVTLB and a TLBFILL index generator (define TLB_FILL_LFSR_EN for an LFSR instead of a counter).
module tlb #(
    parameter int TLBNUM = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [18:0] s0_vppn,
    input  logic        s0_va_bit12,
    input  logic [9:0]  s0_asid,
    output logic        s0_found,
    output logic [3:0]  s0_index,
    output logic [19:0] s0_ppn,
    output logic [5:0]  s0_ps,
    output logic [1:0]  s0_plv,
    output logic [1:0]  s0_mat,
    output logic        s0_d,
    output logic        s0_v,
    input  logic [18:0] s1_vppn,
    input  logic        s1_va_bit12,
    input  logic [9:0]  s1_asid,
    output logic        s1_found,
    output logic [3:0]  s1_index,
    output logic [19:0] s1_ppn,
    output logic [5:0]  s1_ps,
    output logic [1:0]  s1_plv,
    output logic [1:0]  s1_mat,
    output logic        s1_d,
    output logic        s1_v,
    input  logic        we,
    input  logic [3:0]  w_index,
    input  logic        w_e,
    input  logic        w_g,
    input  logic [18:0] w_vppn,
    input  logic [5:0]  w_ps,
    input  logic [9:0]  w_asid,
    input  logic [19:0] w_ppn0,
    input  logic [19:0] w_ppn1,
    input  logic [1:0]  w_plv0,
    input  logic [1:0]  w_plv1,
    input  logic [1:0]  w_mat0,
    input  logic [1:0]  w_mat1,
    input  logic        w_d0,
    input  logic        w_d1,
    input  logic        w_v0,
    input  logic        w_v1,
    input  logic [3:0]  r_index,
    output logic        r_e,
    output logic        r_g,
    output logic [18:0] r_vppn,
    output logic [5:0]  r_ps,
    output logic [9:0]  r_asid,
    output logic [19:0] r_ppn0,
    output logic [19:0] r_ppn1,
    output logic [1:0]  r_plv0,
    output logic [1:0]  r_plv1,
    output logic [1:0]  r_mat0,
    output logic [1:0]  r_mat1,
    output logic        r_d0,
    output logic        r_d1,
    output logic        r_v0,
    output logic        r_v1,
    input  logic        invtlb_valid,
    input  logic [4:0]  invtlb_op,
    input  logic [9:0]  invtlb_asid,
    input  logic [18:0] invtlb_vppn,
    output logic [3:0]  fill_index
);
    logic        tlb_e    [TLBNUM];
    logic        tlb_g    [TLBNUM];
    logic [18:0] tlb_vppn [TLBNUM];
    logic [5:0]  tlb_ps   [TLBNUM];
    logic [9:0]  tlb_asid [TLBNUM];
    logic [19:0] tlb_ppn0 [TLBNUM];
    logic [19:0] tlb_ppn1 [TLBNUM];
    logic [1:0]  tlb_plv0 [TLBNUM];
    logic [1:0]  tlb_plv1 [TLBNUM];
    logic [1:0]  tlb_mat0 [TLBNUM];
    logic [1:0]  tlb_mat1 [TLBNUM];
    logic        tlb_d0   [TLBNUM];
    logic        tlb_d1   [TLBNUM];
    logic        tlb_v0   [TLBNUM];
    logic        tlb_v1   [TLBNUM];

    logic [18:0]       s_vppn  [2];
    logic              s_bit12 [2];
    logic [9:0]        s_asid  [2];
    logic [TLBNUM-1:0] s_hit   [2];
    logic [TLBNUM-1:0] s_odd   [2];
    logic              sel_found [2];
    logic [3:0]        sel_idx   [2];
    logic              sel_odd   [2];
    logic [31:0]       s_res     [2];
    logic [TLBNUM-1:0] inv_hit;

    assign s_vppn[0]  = s0_vppn;
    assign s_vppn[1]  = s1_vppn;
    assign s_bit12[0] = s0_va_bit12;
    assign s_bit12[1] = s1_va_bit12;
    assign s_asid[0]  = s0_asid;
    assign s_asid[1]  = s1_asid;

    // A 4MB entry (ps=21) maps a pair of 2MB pages, so only vppn[18:9] is tagged.
    function automatic logic vppn_eq(input logic big, input logic [18:0] a, input logic [18:0] b);
        return big ? (a[18:9] == b[18:9]) : (a == b);
    endfunction

    generate
        for (genvar gi = 0; gi < TLBNUM; gi++) begin : g_entry
            logic big;
            logic inv_asid;
            logic inv_vppn;
            assign big      = (tlb_ps[gi] == 6'd21);
            assign inv_asid = (tlb_asid[gi] == invtlb_asid);
            assign inv_vppn = vppn_eq(big, tlb_vppn[gi], invtlb_vppn);
            assign inv_hit[gi] = (invtlb_op == 5'd0) || (invtlb_op == 5'd1)
                              || ((invtlb_op == 5'd2) && tlb_g[gi])
                              || ((invtlb_op == 5'd3) && !tlb_g[gi])
                              || ((invtlb_op == 5'd4) && !tlb_g[gi] && inv_asid)
                              || ((invtlb_op == 5'd5) && !tlb_g[gi] && inv_asid && inv_vppn)
                              || ((invtlb_op == 5'd6) && (tlb_g[gi] || inv_asid) && inv_vppn);
            for (genvar gp = 0; gp < 2; gp++) begin : g_port
                assign s_hit[gp][gi] = tlb_e[gi] && (tlb_g[gi] || (tlb_asid[gi] == s_asid[gp]))
                                    && vppn_eq(big, tlb_vppn[gi], s_vppn[gp]);
                assign s_odd[gp][gi] = big ? s_vppn[gp][8] : s_bit12[gp];
            end
        end
    endgenerate

    // Scanning downwards lets the lowest matching index win.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            sel_found[p] = 1'b0;
            sel_idx[p]   = 4'd0;
            sel_odd[p]   = 1'b0;
            for (int i = TLBNUM - 1; i >= 0; i--) begin
                if (s_hit[p][i]) begin
                    sel_found[p] = 1'b1;
                    sel_idx[p]   = i[3:0];
                    sel_odd[p]   = s_odd[p][i];
                end
            end
        end
    end

    generate
        for (genvar gp = 0; gp < 2; gp++) begin : g_result
            assign s_res[gp] = !sel_found[gp] ? 32'd0 :
                sel_odd[gp] ? {tlb_ppn1[sel_idx[gp]], tlb_ps[sel_idx[gp]], tlb_plv1[sel_idx[gp]],
                               tlb_mat1[sel_idx[gp]], tlb_d1[sel_idx[gp]], tlb_v1[sel_idx[gp]]}
                            : {tlb_ppn0[sel_idx[gp]], tlb_ps[sel_idx[gp]], tlb_plv0[sel_idx[gp]],
                               tlb_mat0[sel_idx[gp]], tlb_d0[sel_idx[gp]], tlb_v0[sel_idx[gp]]};
        end
    endgenerate

    assign s0_found = sel_found[0];
    assign s0_index = sel_idx[0];
    assign {s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v} = s_res[0];
    assign s1_found = sel_found[1];
    assign s1_index = sel_idx[1];
    assign {s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v} = s_res[1];

    assign r_e    = tlb_e[r_index];
    assign r_g    = tlb_g[r_index];
    assign r_vppn = tlb_vppn[r_index];
    assign r_ps   = tlb_ps[r_index];
    assign r_asid = tlb_asid[r_index];
    assign r_ppn0 = tlb_ppn0[r_index];
    assign r_ppn1 = tlb_ppn1[r_index];
    assign r_plv0 = tlb_plv0[r_index];
    assign r_plv1 = tlb_plv1[r_index];
    assign r_mat0 = tlb_mat0[r_index];
    assign r_mat1 = tlb_mat1[r_index];
    assign r_d0   = tlb_d0[r_index];
    assign r_d1   = tlb_d1[r_index];
    assign r_v0   = tlb_v0[r_index];
    assign r_v1   = tlb_v1[r_index];

    // The write is issued after the invalidate so a same-cycle write lands with w_e.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TLBNUM; i++) begin
                tlb_e[i]    <= 1'b0;
                tlb_g[i]    <= 1'b0;
                tlb_vppn[i] <= '0;
                tlb_ps[i]   <= '0;
                tlb_asid[i] <= '0;
                tlb_ppn0[i] <= '0;
                tlb_ppn1[i] <= '0;
                tlb_plv0[i] <= '0;
                tlb_plv1[i] <= '0;
                tlb_mat0[i] <= '0;
                tlb_mat1[i] <= '0;
                tlb_d0[i]   <= 1'b0;
                tlb_d1[i]   <= 1'b0;
                tlb_v0[i]   <= 1'b0;
                tlb_v1[i]   <= 1'b0;
            end
        end else begin
            if (invtlb_valid) begin
                for (int i = 0; i < TLBNUM; i++) begin
                    if (inv_hit[i]) tlb_e[i] <= 1'b0;
                end
            end
            if (we) begin
                tlb_e[w_index]    <= w_e;
                tlb_g[w_index]    <= w_g;
                tlb_vppn[w_index] <= w_vppn;
                tlb_ps[w_index]   <= w_ps;
                tlb_asid[w_index] <= w_asid;
                tlb_ppn0[w_index] <= w_ppn0;
                tlb_ppn1[w_index] <= w_ppn1;
                tlb_plv0[w_index] <= w_plv0;
                tlb_plv1[w_index] <= w_plv1;
                tlb_mat0[w_index] <= w_mat0;
                tlb_mat1[w_index] <= w_mat1;
                tlb_d0[w_index]   <= w_d0;
                tlb_d1[w_index]   <= w_d1;
                tlb_v0[w_index]   <= w_v0;
                tlb_v1[w_index]   <= w_v1;
            end
        end
    end

    logic [3:0] fill_q;
    logic [3:0] fill_next;
`ifdef TLB_FILL_LFSR_EN
    localparam logic [3:0] FILL_RESET = 4'b0001;
    assign fill_next = {fill_q[2:0], fill_q[3] ^ fill_q[2]};
`else
    localparam logic [3:0] FILL_RESET = 4'b0000;
    assign fill_next = fill_q + 4'd1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) fill_q <= FILL_RESET;
        else         fill_q <= fill_next;
    end

    assign fill_index = fill_q;
endmodule

// File: tb/tb_tlb.sv
// Self-checking bench for tlb: directed scenarios plus randomized traffic against a page-level reference model.
module tb_tlb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [18:0] s0_vppn, s1_vppn;
    logic        s0_va_bit12, s1_va_bit12;
    logic [9:0]  s0_asid, s1_asid;
    logic        s0_found, s1_found;
    logic [3:0]  s0_index, s1_index;
    logic [19:0] s0_ppn, s1_ppn;
    logic [5:0]  s0_ps, s1_ps;
    logic [1:0]  s0_plv, s1_plv, s0_mat, s1_mat;
    logic        s0_d, s1_d, s0_v, s1_v;
    logic        we;
    logic [3:0]  w_index;
    logic        w_e, w_g;
    logic [18:0] w_vppn;
    logic [5:0]  w_ps;
    logic [9:0]  w_asid;
    logic [19:0] w_ppn0, w_ppn1;
    logic [1:0]  w_plv0, w_plv1, w_mat0, w_mat1;
    logic        w_d0, w_d1, w_v0, w_v1;
    logic [3:0]  r_index;
    logic        r_e, r_g;
    logic [18:0] r_vppn;
    logic [5:0]  r_ps;
    logic [9:0]  r_asid;
    logic [19:0] r_ppn0, r_ppn1;
    logic [1:0]  r_plv0, r_plv1, r_mat0, r_mat1;
    logic        r_d0, r_d1, r_v0, r_v1;
    logic        invtlb_valid;
    logic [4:0]  invtlb_op;
    logic [9:0]  invtlb_asid;
    logic [18:0] invtlb_vppn;
    logic [3:0]  fill_index;

    tlb #(.TLBNUM(16)) dut (
        .clk(clk), .resetn(resetn),
        .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_ppn(s0_ppn), .s0_ps(s0_ps),
        .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
        .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps),
        .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
        .we(we), .w_index(w_index), .w_e(w_e), .w_g(w_g), .w_vppn(w_vppn), .w_ps(w_ps),
        .w_asid(w_asid), .w_ppn0(w_ppn0), .w_ppn1(w_ppn1), .w_plv0(w_plv0), .w_plv1(w_plv1),
        .w_mat0(w_mat0), .w_mat1(w_mat1), .w_d0(w_d0), .w_d1(w_d1), .w_v0(w_v0), .w_v1(w_v1),
        .r_index(r_index), .r_e(r_e), .r_g(r_g), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid),
        .r_ppn0(r_ppn0), .r_ppn1(r_ppn1), .r_plv0(r_plv0), .r_plv1(r_plv1),
        .r_mat0(r_mat0), .r_mat1(r_mat1), .r_d0(r_d0), .r_d1(r_d1), .r_v0(r_v0), .r_v1(r_v1),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
        .invtlb_vppn(invtlb_vppn), .fill_index(fill_index)
    );

    typedef struct packed {
        logic            e;
        logic            g;
        logic [18:0]     vppn;
        logic [5:0]      ps;
        logic [9:0]      asid;
        logic [1:0][19:0] ppn;
        logic [1:0][1:0] plv;
        logic [1:0][1:0] mat;
        logic [1:0]      d;
        logic [1:0]      v;
    } ent_t;

    ent_t        model [16];
    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;
    logic [18:0] pool [6] = '{19'h12345, 19'h12346, 19'h40000, 19'h401AB, 19'h00000, 19'h7FFFF};
    logic [3:0]  seq [17];

    logic [36:0] s0_vec, s1_vec;
    logic [88:0] r_vec;
    assign s0_vec = {s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v};
    assign s1_vec = {s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v};
    assign r_vec  = {r_e, r_g, r_vppn, r_ps, r_asid, r_ppn0, r_ppn1, r_plv0, r_plv1,
                     r_mat0, r_mat1, r_d0, r_d1, r_v0, r_v1};

    // An entry covers a pair of 2^ps pages: compare VA above bit ps, pick the half by VA[ps].
    function automatic bit page_hit(input ent_t x, input logic [18:0] va);
        logic [31:0] a, b;
        a = {x.vppn, 13'd0};
        b = {va, 13'd0};
        return (a >> (x.ps + 6'd1)) == (b >> (x.ps + 6'd1));
    endfunction

    function automatic int half(input ent_t x, input logic [18:0] va, input logic b12);
        logic [31:0] addr;
        addr = {va, b12, 12'd0};
        return int'(addr[x.ps]);
    endfunction

    function automatic logic [36:0] exp_search(input logic [18:0] va, input logic b12, input logic [9:0] asid);
        for (int i = 0; i < 16; i++) begin
            if (model[i].e && (model[i].g || model[i].asid == asid) && page_hit(model[i], va)) begin
                int h;
                h = half(model[i], va, b12);
                return {1'b1, 4'(i), model[i].ppn[h], model[i].ps, model[i].plv[h],
                        model[i].mat[h], model[i].d[h], model[i].v[h]};
            end
        end
        return '0;
    endfunction

    function automatic logic [88:0] exp_read(input ent_t x);
        return {x.e, x.g, x.vppn, x.ps, x.asid, x.ppn[0], x.ppn[1], x.plv[0], x.plv[1],
                x.mat[0], x.mat[1], x.d[0], x.d[1], x.v[0], x.v[1]};
    endfunction

    function automatic bit inv_cond(input ent_t x);
        bit am;
        am = (x.asid == invtlb_asid);
        case (invtlb_op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return x.g;
            5'd3:       return !x.g;
            5'd4:       return !x.g && am;
            5'd5:       return !x.g && am && page_hit(x, invtlb_vppn);
            5'd6:       return (x.g || am) && page_hit(x, invtlb_vppn);
            default:    return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic probe(input string tag);
        #1;
        check({tag, "_s0"}, 128'(s0_vec), 128'(exp_search(s0_vppn, s0_va_bit12, s0_asid)));
        check({tag, "_s1"}, 128'(s1_vec), 128'(exp_search(s1_vppn, s1_va_bit12, s1_asid)));
        check({tag, "_rd"}, 128'(r_vec), 128'(exp_read(model[r_index])));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (resetn) begin
            if (invtlb_valid)
                for (int i = 0; i < 16; i++) if (inv_cond(model[i])) model[i].e = 1'b0;
            if (we) begin
                model[w_index].e = w_e;       model[w_index].g = w_g;
                model[w_index].vppn = w_vppn; model[w_index].ps = w_ps;
                model[w_index].asid = w_asid;
                model[w_index].ppn[0] = w_ppn0; model[w_index].ppn[1] = w_ppn1;
                model[w_index].plv[0] = w_plv0; model[w_index].plv[1] = w_plv1;
                model[w_index].mat[0] = w_mat0; model[w_index].mat[1] = w_mat1;
                model[w_index].d = {w_d1, w_d0}; model[w_index].v = {w_v1, w_v0};
            end
        end
        we = 1'b0;
        invtlb_valid = 1'b0;
    endtask

    task automatic wr(input int idx, input logic e, input logic g, input logic [18:0] vppn,
                      input logic [5:0] ps, input logic [9:0] asid, input logic [19:0] p0, input logic [19:0] p1);
        we = 1'b1; w_index = 4'(idx); w_e = e; w_g = g; w_vppn = vppn; w_ps = ps; w_asid = asid;
        w_ppn0 = p0; w_ppn1 = p1;
        w_plv0 = 2'($urandom); w_plv1 = 2'($urandom); w_mat0 = 2'($urandom); w_mat1 = 2'($urandom);
        w_d0 = 1'($urandom); w_d1 = 1'($urandom); w_v0 = 1'b1; w_v1 = 1'($urandom);
    endtask

    function automatic logic [18:0] rvppn();
        logic [18:0] v;
        v = pool[$urandom_range(0, 5)];
        if ($urandom_range(0, 1) == 1) v[8:0] = 9'($urandom);
        return v;
    endfunction

    task automatic rnd_s1();
        s1_vppn = rvppn(); s1_va_bit12 = 1'($urandom); s1_asid = 10'(5 + $urandom_range(0, 2));
    endtask

    task automatic set_s0(input logic [18:0] v, input logic b12, input logic [9:0] a);
        s0_vppn = v; s0_va_bit12 = b12; s0_asid = a;
        rnd_s1();
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s0_vppn = model[i].vppn; s0_va_bit12 = 1'($urandom); s0_asid = model[i].asid;
            rnd_s1();
            r_index = 4'(i);
            probe(tag);
        end
    endtask

    initial begin
`ifdef TLB_FILL_LFSR_EN
        seq = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10, 4'd5, 4'd11, 4'd7, 4'd15,
                4'd14, 4'd12, 4'd8, 4'd1, 4'd2};
`else
        seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11,
                4'd12, 4'd13, 4'd14, 4'd15, 4'd0};
`endif
        for (int i = 0; i < 16; i++) model[i] = '0;
        resetn = 1'b0; we = 1'b0; invtlb_valid = 1'b0; invtlb_op = '0; invtlb_asid = '0;
        invtlb_vppn = '0; r_index = 4'd3;
        wr(3, 1'b1, 1'b0, 19'h12345, 6'd12, 10'd5, 20'hAAAAA, 20'hBBBBB);
        we = 1'b0;
        set_s0(19'h12345, 1'b1, 10'd5);
        check("reset_s0", 128'(s0_vec), 128'd0);
        check("reset_s1", 128'(s1_vec), 128'd0);
        check("reset_rd", 128'(r_vec), 128'd0);
        check("reset_fill", 128'(fill_index), 128'(seq[0]));
        // A write strobed while held in reset must be dropped.
        we = 1'b1;
        tick();
        check("reset_wr_drop", 128'(r_vec), 128'd0);
        #2 resetn = 1'b1;

        wr(3, 1'b1, 1'b0, 19'h12345, 6'd12, 10'd5, 20'hAAAAA, 20'hBBBBB);
        tick();
        set_s0(19'h12345, 1'b1, 10'd5);
        check("idx3_hit", 128'({s0_found, s0_index, s0_ppn, s0_ps}), 128'({1'b1, 4'd3, 20'hBBBBB, 6'd12}));
        probe("idx3");
        set_s0(19'h12345, 1'b1, 10'd6);
        check("idx3_asid_miss", 128'(s0_vec), 128'd0);

        wr(7, 1'b1, 1'b1, 19'h40000, 6'd21, 10'd9, 20'h0C0C0, 20'h0D0D0);
        tick();
        set_s0(19'h400FF, 1'b0, 10'd1);
        check("huge_even", 128'({s0_found, s0_index, s0_ppn, s0_ps}), 128'({1'b1, 4'd7, 20'h0C0C0, 6'd21}));
        set_s0(19'h401FF, 1'b0, 10'd1);
        check("huge_odd", 128'({s0_found, s0_index, s0_ppn}), 128'({1'b1, 4'd7, 20'h0D0D0}));
        probe("huge");

        wr(9, 1'b1, 1'b0, 19'h2AAAA, 6'd12, 10'd5, 20'h99999, 20'h99999);
        tick();
        wr(2, 1'b1, 1'b0, 19'h2AAAA, 6'd12, 10'd5, 20'h22222, 20'h22222);
        tick();
        set_s0(19'h2AAAA, 1'b0, 10'd5);
        check("multi_lowest", 128'({s0_found, s0_index, s0_ppn}), 128'({1'b1, 4'd2, 20'h22222}));

        invtlb_valid = 1'b1; invtlb_op = 5'd0;
        tick();
        check_all("inv_all");
        wr(0, 1'b1, 1'b1, 19'h01000, 6'd12, 10'd7, 20'h10000, 20'h10001); tick();
        wr(1, 1'b1, 1'b0, 19'h02000, 6'd12, 10'd5, 20'h20000, 20'h20001); tick();
        wr(2, 1'b1, 1'b0, 19'h03000, 6'd12, 10'd6, 20'h30000, 20'h30001); tick();
        wr(3, 1'b1, 1'b0, 19'h04000, 6'd21, 10'd5, 20'h40000, 20'h40001); tick();
        wr(4, 1'b1, 1'b1, 19'h05000, 6'd12, 10'd5, 20'h50000, 20'h50001); tick();
        check_all("mix");
        invtlb_valid = 1'b1; invtlb_op = 5'd4; invtlb_asid = 10'd5;
        tick();
        set_s0(19'h02000, 1'b0, 10'd5);
        check("op4_asid5_miss", 128'(s0_found), 128'd0);
        set_s0(19'h05000, 1'b0, 10'd5);
        check("op4_global_keep", 128'({s0_found, s0_index}), 128'({1'b1, 4'd4}));
        check_all("op4");
        invtlb_valid = 1'b1; invtlb_op = 5'd2;
        tick();
        set_s0(19'h01000, 1'b0, 10'd7);
        check("op2_global_miss", 128'(s0_found), 128'd0);
        set_s0(19'h03000, 1'b0, 10'd6);
        check("op2_asid6_keep", 128'({s0_found, s0_index}), 128'({1'b1, 4'd2}));
        invtlb_valid = 1'b1; invtlb_op = 5'd9;
        tick();
        set_s0(19'h03000, 1'b0, 10'd6);
        check("op9_noop", 128'({s0_found, s0_index}), 128'({1'b1, 4'd2}));
        check_all("op9");

        wr(4, 1'b1, 1'b0, 19'h06000, 6'd12, 10'd5, 20'h11111, 20'h22222);
        tick();
        wr(4, 1'b1, 1'b0, 19'h0ABCD, 6'd12, 10'd5, 20'h33333, 20'h44444);
        invtlb_valid = 1'b1; invtlb_op = 5'd0;
        set_s0(19'h06000, 1'b0, 10'd5);
        check("same_cycle_old", 128'({s0_found, s0_index, s0_ppn}), 128'({1'b1, 4'd4, 20'h11111}));
        tick();
        set_s0(19'h0ABCD, 1'b1, 10'd5);
        check("wr_after_inv", 128'({s0_found, s0_index, s0_ppn}), 128'({1'b1, 4'd4, 20'h44444}));
        for (int i = 0; i < 16; i++) begin
            r_index = 4'(i);
            #1;
            check($sformatf("only_idx4_e%0d", i), 128'(r_e), 128'(i == 4));
        end

        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) < 6)
                wr($urandom_range(0, 15), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                   rvppn(), ($urandom_range(0, 1) == 1) ? 6'd21 : 6'd12,
                   10'(5 + $urandom_range(0, 2)), 20'($urandom), 20'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                invtlb_valid = 1'b1; invtlb_op = 5'($urandom_range(0, 9));
                invtlb_asid = 10'(5 + $urandom_range(0, 2)); invtlb_vppn = rvppn();
            end
            s0_vppn = rvppn(); s0_va_bit12 = 1'($urandom); s0_asid = 10'(5 + $urandom_range(0, 2));
            rnd_s1();
            r_index = 4'($urandom);
            probe($sformatf("rand%0d", n));
            tick();
        end

        resetn = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        #1;
        check("rst2_fill", 128'(fill_index), 128'(seq[0]));
        check("rst2_s0", 128'(s0_vec), 128'd0);
        #2 resetn = 1'b1;
        for (int k = 0; k < 17; k++) begin
            check($sformatf("fill%0d", k), 128'(fill_index), 128'(seq[k]));
            tick();
        end
        for (int k = 0; k < 5; k++) tick();
        resetn = 1'b0;
        #1;
        check("midrst_fill", 128'(fill_index), 128'(seq[0]));
        wr(5, 1'b1, 1'b1, 19'h12345, 6'd12, 10'd5, 20'hFFFFF, 20'hFFFFF);
        r_index = 4'd5;
        tick();
        check("midrst_fill_hold", 128'(fill_index), 128'(seq[0]));
        check("midrst_wr_drop", 128'(r_vec), 128'd0);
        #2 resetn = 1'b1;
        check_all("post_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
